// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: debounces the player buttons, moves a 3x3 cursor,
// alternates X/O placements on the board register and detects win and draw.
module ttt_turn_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned DB_W            = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic        place,
   input  logic        first_p2,
   output logic [17:0] board,
   output logic [3:0]  cursor,
   output logic        turn,
   output logic [6:0]  state,
   output logic [1:0]  winner,
   output logic [7:0]  win_line,
   output logic [3:0]  move_count,
   output logic        illegal
);

   localparam int unsigned NBTN  = 5;
   localparam int unsigned NCELL = 9;
   localparam int unsigned PLACE_IDX = 4;

   typedef enum logic [6:0] {
      S_INIT = 7'b0000001,
      S_W1P  = 7'b0000010,
      S_W1R  = 7'b0000100,
      S_W2P  = 7'b0001000,
      S_W2R  = 7'b0010000,
      S_WIN  = 7'b0100000,
      S_DRAW = 7'b1000000
   } state_t;

   localparam logic [1:0] MARK_X = 2'b01;
   localparam logic [1:0] MARK_O = 2'b10;

   state_t            st;
   logic [NBTN-1:0]   raw_btn;
   logic [NBTN-1:0]   db_pulse;
   logic              place_lvl;
   logic              p_up, p_down, p_left, p_right, p_place;
   logic [1:0]        cur_mark;
   logic [17:0]       board_wr;
   logic [7:0]        cur_lines;
   logic [1:0]        cell_sel;

   assign raw_btn = {place, right, left, down, up};

   // Per-button 2-flop synchronizer, stability counter and rising-edge pulse
   for (genvar g = 0; g < NBTN; g++) begin : g_btn
      logic            s1, s2, lvl, pls;
      logic [DB_W-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            lvl <= 1'b0;
            pls <= 1'b0;
            cnt <= '0;
         end else begin
            s1  <= raw_btn[g];
            s2  <= s1;
            pls <= 1'b0;
            if (s2 == lvl) begin
               cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               lvl <= s2;
               cnt <= '0;
               pls <= s2;
            end else begin
               cnt <= cnt + DB_W'(1);
            end
         end
      end

      assign db_pulse[g] = pls;

      if (g == PLACE_IDX) begin : g_lvl
         assign place_lvl = lvl;
      end
   end

   assign p_up    = db_pulse[0];
   assign p_down  = db_pulse[1];
   assign p_left  = db_pulse[2];
   assign p_right = db_pulse[3];
   assign p_place = db_pulse[4];

   function automatic logic [3:0] step_cursor(input logic [3:0] c, input logic u,
                                              input logic d, input logic l, input logic r);
      logic [1:0] row, col;
      if (c >= 4'd6) begin
         row = 2'd2;
         col = 2'(c - 4'd6);
      end else if (c >= 4'd3) begin
         row = 2'd1;
         col = 2'(c - 4'd3);
      end else begin
         row = 2'd0;
         col = 2'(c);
      end
      if (u)      row = (row == 2'd0) ? 2'd2 : row - 2'd1;
      else if (d) row = (row == 2'd2) ? 2'd0 : row + 2'd1;
      else if (l) col = (col == 2'd0) ? 2'd2 : col - 2'd1;
      else if (r) col = (col == 2'd2) ? 2'd0 : col + 2'd1;
      return ({2'b00, row} * 4'd3) + {2'b00, col};
   endfunction

   function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] m);
      logic [NCELL-1:0] eq;
      for (int i = 0; i < NCELL; i++) eq[i] = (b[2*i +: 2] == m);
      lines_of[0] = eq[0] & eq[1] & eq[2];
      lines_of[1] = eq[3] & eq[4] & eq[5];
      lines_of[2] = eq[6] & eq[7] & eq[8];
      lines_of[3] = eq[0] & eq[3] & eq[6];
      lines_of[4] = eq[1] & eq[4] & eq[7];
      lines_of[5] = eq[2] & eq[5] & eq[8];
      lines_of[6] = eq[0] & eq[4] & eq[8];
      lines_of[7] = eq[2] & eq[4] & eq[6];
   endfunction

   // The mover's mark follows turn, which tracks the WAIT1/WAIT2 state pairs
   assign cur_mark  = turn ? MARK_O : MARK_X;
   assign cur_lines = lines_of(board, cur_mark);

   always_comb begin
      board_wr = board;
      cell_sel = 2'b00;
      for (int i = 0; i < NCELL; i++) begin
         if (cursor == 4'(i)) begin
            board_wr[2*i +: 2] = cur_mark;
            cell_sel           = board[2*i +: 2];
         end
      end
   end

   assign state = st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= S_INIT;
         board      <= '0;
         cursor     <= 4'd4;
         turn       <= 1'b0;
         winner     <= 2'b00;
         win_line   <= '0;
         move_count <= '0;
         illegal    <= 1'b0;
      end else begin
         illegal <= 1'b0;
         case (st)
            S_INIT: begin
               board      <= '0;
               winner     <= 2'b00;
               win_line   <= '0;
               move_count <= '0;
               cursor     <= 4'd4;
               if (first_p2) begin
                  st   <= S_W2P;
                  turn <= 1'b1;
               end else begin
                  st   <= S_W1P;
                  turn <= 1'b0;
               end
            end
            S_W1P, S_W2P: begin
               // place outranks every direction pulse in the same cycle
               if (p_place) begin
                  if (cell_sel == 2'b00) begin
                     board      <= board_wr;
                     move_count <= move_count + 4'd1;
                     st         <= (st == S_W1P) ? S_W1R : S_W2R;
                  end else begin
                     illegal <= 1'b1;
                  end
               end else if (p_up || p_down || p_left || p_right) begin
                  cursor <= step_cursor(cursor, p_up, p_down, p_left, p_right);
               end
            end
            S_W1R, S_W2R: begin
               if (!place_lvl) begin
                  if (|cur_lines) begin
                     st       <= S_WIN;
                     winner   <= cur_mark;
                     win_line <= cur_lines;
                  end else if (move_count == 4'd9) begin
                     st <= S_DRAW;
                  end else if (st == S_W1R) begin
                     st   <= S_W2P;
                     turn <= 1'b1;
                  end else begin
                     st   <= S_W1P;
                     turn <= 1'b0;
                  end
               end
            end
            S_WIN, S_DRAW: begin
               if (p_place) st <= S_INIT;
            end
            default: st <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed bench for ttt_turn_controller with a short debounce window.
module tb_ttt_turn_controller;

   logic        clk, rst;
   logic        up, down, left, right, place, first_p2;
   logic [17:0] board;
   logic [3:0]  cursor;
   logic        turn;
   logic [6:0]  state;
   logic [1:0]  winner;
   logic [7:0]  win_line;
   logic [3:0]  move_count;
   logic        illegal;

   localparam logic [4:0] B_UP = 5'h01, B_DN = 5'h02, B_LF = 5'h04, B_RT = 5'h08, B_PL = 5'h10;
   localparam logic [6:0] ST_INIT = 7'h01, ST_W1P = 7'h02, ST_W1R = 7'h04, ST_W2P = 7'h08,
                          ST_WIN = 7'h20, ST_DRAW = 7'h40;

   ttt_turn_controller #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
      .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
      .place(place), .first_p2(first_p2), .board(board), .cursor(cursor),
      .turn(turn), .state(state), .winner(winner), .win_line(win_line),
      .move_count(move_count), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  btn;
      logic [3:0]  cur;
      logic [6:0]  st;
      logic [17:0] brd;
      logic [3:0]  mc;
      logic        trn;
   } vec_t;

   vec_t tv[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   seg_cur, seg_win, seg_win2, seg_draw, seg_end;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic add(input logic [4:0] b, input logic [3:0] c, input logic [6:0] s,
                      input logic [17:0] bd, input logic [3:0] m, input logic t);
      vec_t v;
      v.btn = b; v.cur = c; v.st = s; v.brd = bd; v.mc = m; v.trn = t;
      tv.push_back(v);
   endtask

   task automatic set_btns(input logic [4:0] m);
      {place, right, left, down, up} = m;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [4:0] m);
      set_btns(m);
      cyc(8);
      set_btns(5'h00);
      cyc(8);
   endtask

   task automatic run(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         press(tv[i].btn);
         chk($sformatf("v%0d.cursor", i), 32'(cursor), 32'(tv[i].cur));
         chk($sformatf("v%0d.state", i), 32'(state), 32'(tv[i].st));
         chk($sformatf("v%0d.board", i), 32'(board), 32'(tv[i].brd));
         chk($sformatf("v%0d.moves", i), 32'(move_count), 32'(tv[i].mc));
         chk($sformatf("v%0d.turn", i), 32'(turn), 32'(tv[i].trn));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      first_p2 = 1'b0;
      set_btns(5'h00);

      // cursor walk in WAIT2_PRESS with X already at 4
      seg_cur = tv.size();
      add(B_RT, 4'd5, ST_W2P, 18'h00100, 4'd1, 1'b1);
      add(B_RT, 4'd3, ST_W2P, 18'h00100, 4'd1, 1'b1);
      add(B_UP, 4'd0, ST_W2P, 18'h00100, 4'd1, 1'b1);
      add(B_UP, 4'd6, ST_W2P, 18'h00100, 4'd1, 1'b1);
      add(B_UP | B_RT, 4'd3, ST_W2P, 18'h00100, 4'd1, 1'b1);
      // X wins on row 0
      seg_win = tv.size();
      add(B_UP, 4'd1, ST_W1P, 18'h00000, 4'd0, 1'b0);
      add(B_LF, 4'd0, ST_W1P, 18'h00000, 4'd0, 1'b0);
      add(B_PL, 4'd0, ST_W2P, 18'h00001, 4'd1, 1'b1);
      add(B_DN, 4'd3, ST_W2P, 18'h00001, 4'd1, 1'b1);
      add(B_PL, 4'd3, ST_W1P, 18'h00081, 4'd2, 1'b0);
      add(B_UP, 4'd0, ST_W1P, 18'h00081, 4'd2, 1'b0);
      add(B_RT, 4'd1, ST_W1P, 18'h00081, 4'd2, 1'b0);
      add(B_PL, 4'd1, ST_W2P, 18'h00085, 4'd3, 1'b1);
      add(B_DN, 4'd4, ST_W2P, 18'h00085, 4'd3, 1'b1);
      add(B_PL, 4'd4, ST_W1P, 18'h00285, 4'd4, 1'b0);
      add(B_UP, 4'd1, ST_W1P, 18'h00285, 4'd4, 1'b0);
      add(B_RT, 4'd2, ST_W1P, 18'h00285, 4'd4, 1'b0);
      add(B_PL, 4'd2, ST_WIN, 18'h00295, 4'd5, 1'b0);
      seg_win2 = tv.size();
      add(B_RT, 4'd2, ST_WIN, 18'h00295, 4'd5, 1'b0);
      add(B_PL, 4'd4, ST_W1P, 18'h00000, 4'd0, 1'b0);
      // draw game
      seg_draw = tv.size();
      add(B_UP, 4'd1, ST_W1P, 18'h00000, 4'd0, 1'b0);
      add(B_LF, 4'd0, ST_W1P, 18'h00000, 4'd0, 1'b0);
      add(B_PL, 4'd0, ST_W2P, 18'h00001, 4'd1, 1'b1);
      add(B_RT, 4'd1, ST_W2P, 18'h00001, 4'd1, 1'b1);
      add(B_PL, 4'd1, ST_W1P, 18'h00009, 4'd2, 1'b0);
      add(B_RT, 4'd2, ST_W1P, 18'h00009, 4'd2, 1'b0);
      add(B_PL, 4'd2, ST_W2P, 18'h00019, 4'd3, 1'b1);
      add(B_DN, 4'd5, ST_W2P, 18'h00019, 4'd3, 1'b1);
      add(B_LF, 4'd4, ST_W2P, 18'h00019, 4'd3, 1'b1);
      add(B_PL, 4'd4, ST_W1P, 18'h00219, 4'd4, 1'b0);
      add(B_LF, 4'd3, ST_W1P, 18'h00219, 4'd4, 1'b0);
      add(B_PL, 4'd3, ST_W2P, 18'h00259, 4'd5, 1'b1);
      add(B_RT, 4'd4, ST_W2P, 18'h00259, 4'd5, 1'b1);
      add(B_RT, 4'd5, ST_W2P, 18'h00259, 4'd5, 1'b1);
      add(B_PL, 4'd5, ST_W1P, 18'h00A59, 4'd6, 1'b0);
      add(B_DN, 4'd8, ST_W1P, 18'h00A59, 4'd6, 1'b0);
      add(B_LF, 4'd7, ST_W1P, 18'h00A59, 4'd6, 1'b0);
      add(B_PL, 4'd7, ST_W2P, 18'h04A59, 4'd7, 1'b1);
      add(B_LF, 4'd6, ST_W2P, 18'h04A59, 4'd7, 1'b1);
      add(B_PL, 4'd6, ST_W1P, 18'h06A59, 4'd8, 1'b0);
      add(B_RT, 4'd7, ST_W1P, 18'h06A59, 4'd8, 1'b0);
      add(B_RT, 4'd8, ST_W1P, 18'h06A59, 4'd8, 1'b0);
      add(B_PL, 4'd8, ST_DRAW, 18'h16A59, 4'd9, 1'b0);
      seg_end = tv.size();

      // reset and first cycle out of INIT
      cyc(3);
      rst = 1'b0;
      chk("rst.state", 32'(state), 32'(ST_INIT));
      chk("rst.board", 32'(board), 32'h0);
      chk("rst.cursor", 32'(cursor), 32'd4);
      chk("rst.illegal", 32'(illegal), 32'h0);
      @(negedge clk);
      chk("init.state", 32'(state), 32'(ST_W1P));
      chk("init.moves", 32'(move_count), 32'h0);
      chk("init.turn", 32'(turn), 32'h0);

      // short glitch is filtered
      place = 1'b1;
      cyc(3);
      place = 1'b0;
      cyc(10);
      chk("glitch.state", 32'(state), 32'(ST_W1P));
      chk("glitch.board", 32'(board), 32'h0);

      // long press: pulse after edge k+5, mark visible after edge k+6
      place = 1'b1;
      cyc(6);
      chk("db.early_board", 32'(board), 32'h0);
      chk("db.early_state", 32'(state), 32'(ST_W1P));
      cyc(1);
      chk("db.board", 32'(board), 32'h00100);
      chk("db.state", 32'(state), 32'(ST_W1R));
      chk("db.moves", 32'(move_count), 32'd1);
      cyc(3);
      place = 1'b0;
      cyc(8);
      chk("rel.state", 32'(state), 32'(ST_W2P));
      chk("rel.turn", 32'(turn), 32'h1);

      // O places on the occupied centre
      place = 1'b1;
      cyc(6);
      chk("occ.illegal_pre", 32'(illegal), 32'h0);
      cyc(1);
      chk("occ.illegal", 32'(illegal), 32'h1);
      cyc(1);
      chk("occ.illegal_post", 32'(illegal), 32'h0);
      chk("occ.board", 32'(board), 32'h00100);
      chk("occ.state", 32'(state), 32'(ST_W2P));
      cyc(2);
      place = 1'b0;
      cyc(8);

      run(seg_cur, seg_win);

      do_reset();
      run(seg_win, seg_win2);
      chk("win.winner", 32'(winner), 32'h1);
      chk("win.line", 32'(win_line), 32'h01);
      run(seg_win2, seg_draw);
      chk("win.cleared_winner", 32'(winner), 32'h0);
      chk("win.cleared_line", 32'(win_line), 32'h0);

      first_p2 = 1'b1;
      do_reset();
      chk("p2.state", 32'(state), 32'(ST_W2P));
      chk("p2.turn", 32'(turn), 32'h1);
      chk("p2.cursor", 32'(cursor), 32'd4);
      first_p2 = 1'b0;

      do_reset();
      run(seg_draw, seg_end);
      chk("draw.winner", 32'(winner), 32'h0);
      chk("draw.line", 32'(win_line), 32'h0);

      // asynchronous reset after the fifth move takes effect mid-cycle
      do_reset();
      run(seg_draw, seg_draw + 12);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst.state", 32'(state), 32'(ST_INIT));
      chk("arst.board", 32'(board), 32'h0);
      chk("arst.cursor", 32'(cursor), 32'd4);
      chk("arst.moves", 32'(move_count), 32'h0);
      chk("arst.turn", 32'(turn), 32'h0);
      chk("arst.winner", 32'(winner), 32'h0);
      chk("arst.line", 32'(win_line), 32'h0);
      chk("arst.illegal", 32'(illegal), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst.resume", 32'(state), 32'(ST_W1P));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ttt_turn_controller.md
# ttt_turn_controller

Turn sequencer for the tic-tac-toe game. It debounces the raw player buttons and moves a 3x3 cursor. It alternates X and O placements, owns the board register and detects win and draw. Its board, cursor and one-hot state outputs feed the VGA renderer and the seven-segment status digits in the top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a synchronized input changes its debounced level (minimum 2).
- `DB_W`, default 20: width of each debounce counter (2^DB_W > DEBOUNCE_CYCLES).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `up`, `down`, `left`, `right`  in  1 each  raw cursor buttons, asynchronous to `clk`.
- `place`  in  1  raw place/confirm button, asynchronous.
- `first_p2`  in  1  level; 1 = O moves first. Sampled only in INIT.
- `board`  out  18  cell i at bits [2i+1:2i], row-major; 00 empty, 01 X, 10 O.
- `cursor`  out  4  selected cell 0..8.
- `turn`  out  1  0 = X to move, 1 = O to move.
- `state`  out  7  one-hot {DRAW, WIN, WAIT2_RELEASE, WAIT2_PRESS, WAIT1_RELEASE, WAIT1_PRESS, INIT}.
- `winner`  out  2  00 none, 01 X, 10 O.
- `win_line`  out  8  bits 0-2 rows, 3-5 columns, 6 diagonal (0,4,8), 7 anti-diagonal (2,4,6).
- `move_count`  out  4  marks placed, 0..9.
- `illegal`  out  1  one-cycle pulse when a place targets an occupied cell.

## Operation
- Input conditioning, per button:
  - 2-flop synchronizer, then a debounce counter.
  - Any cycle where the synchronized value equals the debounced level clears the counter.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A registered one-cycle pulse is issued on each debounced rising edge.
- FSM states: INIT, WAIT1_PRESS, WAIT1_RELEASE, WAIT2_PRESS, WAIT2_RELEASE, WIN, DRAW.
  - INIT: clear board, winner, win_line and move_count; set cursor=4. Next state is WAIT2_PRESS if `first_p2`, else WAIT1_PRESS. Lasts exactly one cycle.
  - WAITn_PRESS, place pulse on an empty cell: write the mark (X for n=1, O for n=2), increment move_count, go to WAITn_RELEASE.
  - WAITn_PRESS, place pulse on an occupied cell: pulse `illegal`, leave the board unchanged, stay in the state.
  - WAITn_RELEASE: wait until the debounced `place` level is 0. Then:
    - If any line holds three of the current mark: go to WIN, latch `winner` and `win_line`. All completed lines are flagged.
    - Else if move_count==9: go to DRAW.
    - Else go to the other player's WAIT_PRESS.
  - Win takes precedence over draw on the 9th move.
  - WIN and DRAW: hold. A place pulse goes to INIT. Direction pulses are ignored.
- Cursor moves only in WAIT1_PRESS and WAIT2_PRESS:
  - `right`/`left` change the column with wrap inside the row (2→0, 0→2).
  - `down`/`up` change the row with wrap (row 2→0, 0→2).
- Simultaneous pulses in the same cycle:
  - A place pulse suppresses all direction pulses.
  - Among direction pulses, priority is up > down > left > right; one move per cycle.
- `turn` = 1 in WAIT2_PRESS and WAIT2_RELEASE, 0 in WAIT1_PRESS and WAIT1_RELEASE. In WIN, DRAW and INIT it holds its last value.

## Timing
- Reset values:
  - state = INIT (0000001); board, winner, win_line, move_count all 0.
  - cursor = 4, turn = 0, illegal = 0.
  - All synchronizers, counters, debounced levels and pulses at 0.
- Reset mid-game abandons the game immediately, with no pending writes.
- Raw edge latency: if edge k is the first to sample a raw 1 that stays stable, the pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles (at the synchronizer output) produces no pulse.
- Board, move_count and the state change update on the same edge that consumes the place pulse. The mark is visible the following cycle.
- `illegal` is asserted for exactly the cycle after the rejected pulse.
- The WIN/DRAW decision is registered one cycle after the debounced release is observed.
- All outputs are registered and glitch-free.

## Test plan
DEBOUNCE_CYCLES=4 throughout.
- Reset: assert rst mid-clock, deassert → state=0000001, then WAIT1_PRESS (0000010) next cycle; board=0, cursor=4, move_count=0.
- Debounce: place high 3 cycles → no pulse, state unchanged. Place high 10 cycles → exactly one pulse at edge k+5, X written at cell 4 (board=18'h00100).
- Cursor wrap: from 4, right, right → 5, 3. Then up, up → 0, 6. Up and right pulsed together → up applied only.
- Occupied: X at 4, O presses place on 4 → `illegal` for 1 cycle, board unchanged, state stays WAIT2_PRESS.
- X win on row 0: X0, O3, X1, O4, X2 → WIN, winner=01, win_line=00000001. Further direction pulses ignored. Place → INIT → WAIT1_PRESS, board cleared. Repeat with first_p2=1 → WAIT2_PRESS.
- Draw and reset: X0, O1, X2, O4, X3, O5, X7, O6, X8 → DRAW, move_count=9, winner=00. Separately, async reset after the 5th move → all reset values within the same cycle.
